// File: rtl/ceespu_dmem_ctrl_if.sv
// Core data-memory bus for the ceespu data-memory controller: core access
// port, block-RAM port and slow I/O peripheral port bundled together.
interface ceespu_dmem_ctrl_if;
    // Core side
    logic        I_en;
    logic [15:0] I_addr;
    logic [31:0] I_wdata;
    logic [3:0]  I_we;
    logic [31:0] O_rdata;
    logic        O_busy;
    logic        O_bus_error;
    // Block-RAM side
    logic        O_ram_en;
    logic [13:0] O_ram_addr;
    logic [31:0] O_ram_wdata;
    logic [3:0]  O_ram_we;
    logic [31:0] I_ram_rdata;
    // I/O peripheral side
    logic        O_io_req;
    logic [15:0] O_io_addr;
    logic [31:0] O_io_wdata;
    logic [3:0]  O_io_we;
    logic        I_io_ack;
    logic [31:0] I_io_rdata;

    // Controller view
    modport slave (
        input  I_en, I_addr, I_wdata, I_we,
        output O_rdata, O_busy, O_bus_error,
        output O_ram_en, O_ram_addr, O_ram_wdata, O_ram_we,
        input  I_ram_rdata,
        output O_io_req, O_io_addr, O_io_wdata, O_io_we,
        input  I_io_ack, I_io_rdata
    );

    // Core / memory / peripheral view
    modport master (
        output I_en, I_addr, I_wdata, I_we,
        input  O_rdata, O_busy, O_bus_error,
        input  O_ram_en, O_ram_addr, O_ram_wdata, O_ram_we,
        output I_ram_rdata,
        input  O_io_req, O_io_addr, O_io_wdata, O_io_we,
        output I_io_ack, I_io_rdata
    );
endinterface

// File: rtl/ceespu_dmem_ctrl.sv
// Data-memory controller for the ceespu core. Addresses with bit 15 clear go
// to zero-wait block RAM; addresses with bit 15 set go to a slow req/ack I/O
// port, stalling the core via O_busy until the peripheral acks or times out.
module ceespu_dmem_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic             I_clk,
    input logic             I_rst,
    ceespu_dmem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_WAIT = 2'd1,
        IO_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   waitCnt;
    logic [31:0]        rdReg;
    logic               srcIo;       // region of the last accepted access
    logic               busy;
    logic               ioLaunch;
    logic               ackHit;
    logic               timeoutHit;
    logic               ramEn;

    // Next-state decode, stall request and I/O completion events
    always_comb begin
        stateNext  = state;
        busy       = 1'b0;
        ioLaunch   = 1'b0;
        ackHit     = 1'b0;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.I_en && bus.I_addr[15]) begin
                    busy      = 1'b1;
                    ioLaunch  = 1'b1;
                    stateNext = IO_WAIT;
                end
            end
            IO_WAIT: begin
                busy = 1'b1;
                // An ack arriving on the last allowed cycle still completes normally
                if (bus.I_io_ack) begin
                    ackHit    = 1'b1;
                    stateNext = IO_DONE;
                end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    timeoutHit = 1'b1;
                    stateNext  = IO_DONE;
                end
            end
            IO_DONE: begin
                // Core advances past the held request here; it is not relaunched
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // RAM port is a straight pass-through, gated to IDLE so an I/O access never touches RAM
    always_comb begin
        ramEn           = bus.I_en & ~bus.I_addr[15] & (state == IDLE);
        bus.O_ram_en    = ramEn;
        bus.O_ram_addr  = bus.I_addr[15:2];
        bus.O_ram_wdata = bus.I_wdata;
        bus.O_ram_we    = ramEn ? bus.I_we : 4'b0000;
        bus.O_busy      = busy;
        bus.O_rdata     = srcIo ? rdReg : bus.I_ram_rdata;
    end

    // Control state: FSM, request strobe, timeout counter, error pulse, read-source select
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state           <= IDLE;
            bus.O_io_req    <= 1'b0;
            bus.O_bus_error <= 1'b0;
            waitCnt         <= '0;
            srcIo           <= 1'b0;
        end else begin
            state           <= stateNext;
            bus.O_bus_error <= timeoutHit;
            if (ioLaunch) begin
                bus.O_io_req <= 1'b1;
                waitCnt      <= '0;
            end else if (state == IO_WAIT) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (ackHit || timeoutHit) begin
                bus.O_io_req <= 1'b0;
            end
            if (!busy && bus.I_en) begin
                srcIo <= bus.I_addr[15];
            end
        end
    end

    // I/O datapath: request capture at launch and read-data capture at completion
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            bus.O_io_addr  <= '0;
            bus.O_io_wdata <= '0;
            bus.O_io_we    <= '0;
            rdReg          <= '0;
        end else begin
            if (ioLaunch) begin
                bus.O_io_addr  <= bus.I_addr;
                bus.O_io_wdata <= bus.I_wdata;
                bus.O_io_we    <= bus.I_we;
            end
            // Stores and timeouts return zero so the core never sees stale data
            if (ackHit) begin
                rdReg <= (bus.O_io_we == 4'b0000) ? bus.I_io_rdata : 32'h0;
            end else if (timeoutHit) begin
                rdReg <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_ceespu_dmem_ctrl.sv
// Scoreboard bench for ceespu_dmem_ctrl: a core driver issues directed and
// random accesses, a block-RAM model and an I/O peripheral model respond, and
// a monitor checks every accepted access against expectations computed from
// a byte-level reference memory and the peripheral's chosen ack delay.
module tb_ceespu_dmem_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;
    localparam logic [31:0] JUNK = 32'hDEAD_0BAD;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        int          busyCycles;
        logic        err;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] data;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } io_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ceespu_dmem_ctrl_if bus();

    ceespu_dmem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    int   nCmp = 0;
    int   nFail = 0;
    exp_t sb[$];
    io_t  ioQ[$];
    int   ioIssued = 0;
    int   reqSeen = 0;
    int   expErr = 0;
    int   errSeen = 0;
    logic monOn = 1'b0;

    logic [31:0] refMem [0:255];
    logic [31:0] bram [0:16383];
    logic [31:0] ramQ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Synchronous block RAM, one-cycle read latency
    always @(posedge clk) begin
        if (bus.O_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.O_ram_we[b]) bram[bus.O_ram_addr][8*b +: 8] <= bus.O_ram_wdata[8*b +: 8];
            ramQ <= bram[bus.O_ram_addr];
        end
    end
    assign bus.I_ram_rdata = ramQ;

    // I/O peripheral: acks in the delay-th wait cycle (late or never if beyond the timeout)
    initial begin
        io_t cur;
        int  cnt;
        logic active;
        active = 1'b0;
        cnt = 0;
        bus.I_io_ack   = 1'b0;
        bus.I_io_rdata = JUNK;
        forever begin
            @(posedge clk);
            #1;
            if (bus.I_io_ack) begin
                bus.I_io_ack   = 1'b0;
                bus.I_io_rdata = JUNK;
            end
            if (active) begin
                cnt++;
                if (!bus.O_io_req) begin
                    active = 1'b0;
                    if (cnt == cur.delay) begin
                        bus.I_io_ack   = 1'b1;
                        bus.I_io_rdata = cur.data;
                    end
                end else if (cnt == cur.delay) begin
                    bus.I_io_ack   = 1'b1;
                    bus.I_io_rdata = cur.data;
                end
            end else if (bus.O_io_req) begin
                reqSeen++;
                if (ioQ.size() == 0) begin
                    check("io_unexpected_req", 32'd1, 32'd0);
                end else begin
                    cur = ioQ.pop_front();
                    check("io_addr", {16'h0, bus.O_io_addr}, {16'h0, cur.addr});
                    check("io_we", {28'h0, bus.O_io_we}, {28'h0, cur.we});
                    check("io_wdata", bus.O_io_wdata, cur.wdata);
                    active = 1'b1;
                    cnt = 1;
                    if (cur.delay == 1) begin
                        bus.I_io_ack   = 1'b1;
                        bus.I_io_rdata = cur.data;
                    end
                end
            end
        end
    end

    // Monitor: finds accepting cycles, pops expectations, checks stall length, error and read data
    initial begin
        exp_t cur;
        logic pend;
        int   busyCnt;
        pend = 1'b0;
        busyCnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (bus.O_bus_error === 1'b1) errSeen++;
            if (pend) begin
                if (cur.chk) check("rdata", bus.O_rdata, cur.data);
                pend = 1'b0;
            end
            if (!monOn) begin
                busyCnt = 0;
            end else if (bus.I_en) begin
                if (bus.O_busy) begin
                    busyCnt++;
                end else if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    check("busy_cycles", busyCnt, cur.busyCycles);
                    check("bus_error", {31'h0, bus.O_bus_error}, {31'h0, cur.err});
                    pend = 1'b1;
                    busyCnt = 0;
                end
            end
        end
    end

    // Present one access and hold it until the controller accepts it
    task automatic doTxn(input logic [15:0] addr, input logic [3:0] we, input logic [31:0] wd,
                         input int delay, input logic [31:0] iodata);
        exp_t e;
        io_t  p;
        int   guard;
        @(negedge clk);
        bus.I_en = 1'b1;
        bus.I_addr = addr;
        bus.I_we = we;
        bus.I_wdata = wd;
        if (addr[15]) begin
            p.delay = delay; p.data = iodata; p.addr = addr; p.wdata = wd; p.we = we;
            ioQ.push_back(p);
            ioIssued++;
            e.err = (delay > TIMEOUT);
            e.busyCycles = 1 + ((delay <= TIMEOUT) ? delay : TIMEOUT);
            e.chk = 1'b1;
            e.data = (we == 4'b0000 && delay <= TIMEOUT) ? iodata : 32'h0;
            if (e.err) expErr++;
        end else begin
            e.err = 1'b0;
            e.busyCycles = 0;
            if (we == 4'b0000) begin
                e.chk = 1'b1;
                e.data = refMem[addr[9:2]];
            end else begin
                e.chk = 1'b0;
                e.data = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (we[b]) refMem[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end
        sb.push_back(e);
        #1;
        if (addr[15]) begin
            check("ram_en_io", {31'h0, bus.O_ram_en}, 32'h0);
        end else begin
            check("ram_addr", {18'h0, bus.O_ram_addr}, {18'h0, addr[15:2]});
            check("ram_we", {28'h0, bus.O_ram_we}, {28'h0, we});
        end
        guard = 0;
        while (bus.O_busy && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            $display("FAIL busy_stuck: got busy after %0d cycles, expected release", guard);
            $fatal(1, "controller never released busy");
        end
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.I_en = 1'b0;
        bus.I_addr = 16'($urandom);
        bus.I_we = 4'($urandom);
        bus.I_wdata = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [3:0]  w;
        int kind;
        for (int i = 0; i < 256; i++) refMem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) bram[i] = 32'h0;
        ramQ = 32'h0;
        rst = 1'b1;
        bus.I_en = 1'b0;
        bus.I_addr = 16'h0;
        bus.I_we = 4'h0;
        bus.I_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_io_req", {31'h0, bus.O_io_req}, 32'h0);
        check("rst_bus_error", {31'h0, bus.O_bus_error}, 32'h0);
        check("rst_busy", {31'h0, bus.O_busy}, 32'h0);
        check("rst_io_addr", {16'h0, bus.O_io_addr}, 32'h0);
        check("rst_io_we", {28'h0, bus.O_io_we}, 32'h0);
        check("rst_rdata", bus.O_rdata, 32'h0);
        rst = 1'b0;
        monOn = 1'b1;

        // Directed: RAM write/read, I/O read/write, ack on timeout cycle, timeouts, back-to-back
        doTxn(16'h0010, 4'b1111, 32'hCAFEBABE, 0, 0);
        doTxn(16'h0010, 4'b0000, 32'h0, 0, 0);
        doTxn(16'h8004, 4'b0000, 32'h0, TIMEOUT, 32'h12345678);
        doTxn(16'h8100, 4'b0011, 32'hA5A5A5A5, 2, 32'h77777777);
        doTxn(16'h8008, 4'b0000, 32'h0, TIMEOUT + 1, 32'h55555555);
        doTxn(16'h800C, 4'b0000, 32'h0, 50, 32'h66666666);
        doTxn(16'h0020, 4'b1111, 32'h0BADF00D, 0, 0);
        doTxn(16'h0020, 4'b0000, 32'h0, 0, 0);
        doTxn(16'h8000, 4'b0000, 32'h0, 1, 32'h13572468);
        doTxn(16'h8010, 4'b0000, 32'h0, 3, 32'h24681357);
        idleCycle();

        // Random mix of RAM and I/O traffic with occasional idle gaps
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            w = (kind[0]) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if (kind[1]) a = {1'b1, 15'($urandom)};
            else         a = {6'b0, 8'($urandom), 2'($urandom)};
            doTxn(a, w, $urandom, $urandom_range(1, TIMEOUT + 3), $urandom);
            if ($urandom_range(0, 4) == 0) idleCycle();
        end
        idleCycle();
        idleCycle();

        // Reset while waiting on the peripheral: request drops, no error, next RAM access is zero-wait
        monOn = 1'b0;
        @(negedge clk);
        bus.I_en = 1'b1;
        bus.I_addr = 16'h8ABC;
        bus.I_we = 4'b0000;
        begin
            io_t p;
            p.delay = 1000; p.data = 32'h0; p.addr = 16'h8ABC; p.wdata = bus.I_wdata; p.we = 4'b0000;
            ioQ.push_back(p);
            ioIssued++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_io_req", {31'h0, bus.O_io_req}, 32'h1);
        rst = 1'b1;
        bus.I_en = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_io_req", {31'h0, bus.O_io_req}, 32'h0);
        check("midrst_busy", {31'h0, bus.O_busy}, 32'h0);
        check("midrst_bus_error", {31'h0, bus.O_bus_error}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        monOn = 1'b1;
        doTxn(16'h0010, 4'b0000, 32'h0, 0, 0);
        doTxn(16'h0044, 4'b1100, 32'h12AB34CD, 0, 0);
        doTxn(16'h0044, 4'b0000, 32'h0, 0, 0);
        repeat (3) idleCycle();

        check("sb_drained", sb.size(), 32'd0);
        check("io_req_count", reqSeen, ioIssued);
        check("bus_error_count", errSeen, expErr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
